// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the two-requester AXI4 read arbiter: FSM encoding,
// AXI field widths and the burst/size codes used by its requesters.
package axi_rd_arb_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_RESP_W  = 2;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_PROT_W  = 3;

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [AXI_SIZE_W-1:0] SIZE_1B = 3'd0;
    localparam logic [AXI_SIZE_W-1:0] SIZE_2B = 3'd1;
    localparam logic [AXI_SIZE_W-1:0] SIZE_4B = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// requester that did not receive the most recent grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    // Pick the winner from the request pair and the previous grant
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Shares one AXI4 read master between fetch (s0) and load/store (s1); the grant
// is held from address handshake through the last data beat.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s0_arvalid,
    output logic                   s0_arready,
    input  logic [ID_W-1:0]        s0_arid,
    input  logic [ADDR_W-1:0]      s0_araddr,
    input  logic [LEN_W-1:0]       s0_arlen,
    input  logic [AXI_SIZE_W-1:0]  s0_arsize,
    input  logic [AXI_BURST_W-1:0] s0_arburst,
    input  logic [AXI_PROT_W-1:0]  s0_arprot,
    output logic                   s0_rvalid,
    input  logic                   s0_rready,
    output logic [ID_W-1:0]        s0_rid,
    output logic [DATA_W-1:0]      s0_rdata,
    output logic [AXI_RESP_W-1:0]  s0_rresp,
    output logic                   s0_rlast,
    input  logic                   s1_arvalid,
    output logic                   s1_arready,
    input  logic [ID_W-1:0]        s1_arid,
    input  logic [ADDR_W-1:0]      s1_araddr,
    input  logic [LEN_W-1:0]       s1_arlen,
    input  logic [AXI_SIZE_W-1:0]  s1_arsize,
    input  logic [AXI_BURST_W-1:0] s1_arburst,
    input  logic [AXI_PROT_W-1:0]  s1_arprot,
    output logic                   s1_rvalid,
    input  logic                   s1_rready,
    output logic [ID_W-1:0]        s1_rid,
    output logic [DATA_W-1:0]      s1_rdata,
    output logic [AXI_RESP_W-1:0]  s1_rresp,
    output logic                   s1_rlast,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [ID_W-1:0]        m_arid,
    output logic [ADDR_W-1:0]      m_araddr,
    output logic [LEN_W-1:0]       m_arlen,
    output logic [AXI_SIZE_W-1:0]  m_arsize,
    output logic [AXI_BURST_W-1:0] m_arburst,
    output logic [AXI_PROT_W-1:0]  m_arprot,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [ID_W-1:0]        m_rid,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic [AXI_RESP_W-1:0]  m_rresp,
    input  logic                   m_rlast,
    output logic                   busy,
    output logic                   gnt
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_gnt;
    logic       r_last;
    logic       w_winner;
    logic [1:0] w_req;
    logic       w_rready_g;

    assign w_req      = {s1_arvalid, s0_arvalid};
    assign w_rready_g = r_gnt ? s1_rready : s0_rready;

    rr_arb2 u_rr_arb2 (
        .req    (w_req),
        .last   (r_last),
        .winner (w_winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is captured on leaving IDLE; last updates only on a completed burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt  <= 1'b0;
            r_last <= 1'b1;
        end else begin
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_gnt <= w_winner;
            end
            if ((r_state == ST_DATA) && m_rvalid && m_rready && m_rlast) begin
                r_last <= r_gnt;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) w_state_nxt = ST_ADDR;
                else        w_state_nxt = ST_IDLE;
            end
            ST_ADDR: begin
                if (m_arready) w_state_nxt = ST_DATA;
                else           w_state_nxt = ST_ADDR;
            end
            ST_DATA: begin
                if (m_rvalid && w_rready_g && m_rlast) w_state_nxt = ST_IDLE;
                else                                   w_state_nxt = ST_DATA;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs: only the granted side ever sees ready/valid
    always_comb begin
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        case (r_state)
            ST_ADDR: begin
                m_arvalid  = 1'b1;
                s0_arready = ~r_gnt & m_arready;
                s1_arready = r_gnt & m_arready;
            end
            ST_DATA: begin
                m_rready  = w_rready_g;
                s0_rvalid = ~r_gnt & m_rvalid;
                s1_rvalid = r_gnt & m_rvalid;
            end
            default: begin
                m_arvalid = 1'b0;
                m_rready  = 1'b0;
            end
        endcase
    end

    assign m_arid    = r_gnt ? s1_arid    : s0_arid;
    assign m_araddr  = r_gnt ? s1_araddr  : s0_araddr;
    assign m_arlen   = r_gnt ? s1_arlen   : s0_arlen;
    assign m_arsize  = r_gnt ? s1_arsize  : s0_arsize;
    assign m_arburst = r_gnt ? s1_arburst : s0_arburst;
    assign m_arprot  = r_gnt ? s1_arprot  : s0_arprot;

    // R payload is broadcast; rvalid alone selects the receiver
    assign s0_rid   = m_rid;
    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rid   = m_rid;
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;

    assign busy = (r_state != ST_IDLE);
    assign gnt  = r_gnt;

endmodule
